// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Types shared across the CPU datapath.
//   word_t          : 32-bit datapath word, used for every 32-bit bus
//   memctl_state_t  : MEM-stage dcache requester FSM states
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      MC_IDLE,
      MC_WAIT,
      MC_DONE
   } memctl_state_t;

endpackage

// File: rtl/dhit_watchdog.sv
// dhit_watchdog
//   Counts cycles spent waiting on dcache dhit and raises a sticky flag once
//   the wait reaches DHIT_TIMEOUT. The count saturates, and the flag is
//   cleared only by reset.
// Ports
//   CLK      in  clock, rising edge
//   nRST     in  async reset, active low
//   clear    in  request completed: counter back to 0
//   count_en in  request outstanding without dhit this cycle
//   expired  out sticky timeout flag
module dhit_watchdog #(
   parameter int DHIT_TIMEOUT = 256,
   parameter int CNT_W        = 9
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DHIT_TIMEOUT);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = '0;
      else if (count_en && (cnt != LIMIT))
         cnt_nxt = cnt + 1'b1;
   end

   // The flag sets on the edge where the count reaches LIMIT, so it is
   // visible right after the DHIT_TIMEOUT-th unanswered request cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (cnt_nxt == LIMIT)
            expired <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM-stage data-memory requester. Issues dcache read/write requests for
//   the instruction in EX/MEM, stalls the pipeline until dhit, and hands load
//   data to MEM/WB. It also owns the sticky halt.
// Ports
//   CLK, nRST                     clock / async active-low reset
//   ihit                          pipeline-advance enable
//   memread_in, memwrite_in       EX/MEM load / store flags
//   addr_in, store_in             EX/MEM address and store data
//   halt_in                       halt instruction in MEM
//   dhit, dmemload                dcache completion and load data
//   dmemREN, dmemWEN              dcache read / write requests
//   dmemaddr, dmemstore           request address / store data
//   load_data_out                 load data to MEM/WB
//   mem_stall                     pipeline-wide stall
//   halt_out                      sticky halt
//   timeout_err                   sticky dhit watchdog timeout
module mem_stage_ctrl
   import cpu_types_pkg::*;
#(
   parameter int DHIT_TIMEOUT = 256,
   parameter int CNT_W        = 9
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  ihit,
   input  logic  memread_in,
   input  logic  memwrite_in,
   input  word_t addr_in,
   input  word_t store_in,
   input  logic  halt_in,
   input  logic  dhit,
   input  word_t dmemload,
   output logic  dmemREN,
   output logic  dmemWEN,
   output word_t dmemaddr,
   output word_t dmemstore,
   output word_t load_data_out,
   output logic  mem_stall,
   output logic  halt_out,
   output logic  timeout_err
);

   memctl_state_t state, state_nxt;
   word_t         captured;
   logic          halted;
   logic          op;
   logic          req;
   logic          stall;
   logic          advance;

   assign op      = (memread_in | memwrite_in) & ~halted;
   assign advance = ihit & ~stall;

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      stall     = 1'b0;
      case (state)
         MC_IDLE, MC_WAIT: begin
            if (op) begin
               req   = 1'b1;
               stall = ~dhit;
               // On the hit cycle stall is 0, so advance reduces to ihit.
               if (dhit)
                  state_nxt = ihit ? MC_IDLE : MC_DONE;
               else
                  state_nxt = MC_WAIT;
            end else begin
               state_nxt = MC_IDLE;
            end
         end
         // Request already served; hold off so a store is not repeated
         // while the pipeline is frozen by something else.
         MC_DONE: begin
            if (ihit)
               state_nxt = MC_IDLE;
         end
         default: state_nxt = MC_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= MC_IDLE;
         captured <= '0;
         halted   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (req && dhit)
            captured <= dmemload;
         if (halt_in && advance)
            halted <= 1'b1;
      end
   end

   dhit_watchdog #(
      .DHIT_TIMEOUT (DHIT_TIMEOUT),
      .CNT_W        (CNT_W)
   ) u_wd (
      .CLK      (CLK),
      .nRST     (nRST),
      .clear    (req & dhit),
      .count_en (req & ~dhit),
      .expired  (timeout_err)
   );

   // Every output is forced to 0 while reset is held; a request that is
   // pulled mid-wait this way is treated as cancelled by the dcache.
   assign dmemWEN       = nRST & req & memwrite_in;
   assign dmemREN       = nRST & req & memread_in & ~memwrite_in;
   assign dmemaddr      = nRST ? addr_in  : '0;
   assign dmemstore     = nRST ? store_in : '0;
   assign load_data_out = !nRST ? '0 : (dhit ? dmemload : captured);
   assign mem_stall     = nRST & stall;
   assign halt_out      = halted;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
   import cpu_types_pkg::*;

   localparam int TO = 4;

   logic  CLK = 1'b0, nRST = 1'b0, ihit = 1'b0;
   logic  memread_in = 1'b0, memwrite_in = 1'b0, halt_in = 1'b0, dhit = 1'b0;
   word_t addr_in = '0, store_in = '0, dmemload = '0;
   logic  dmemREN, dmemWEN, mem_stall, halt_out, timeout_err;
   word_t dmemaddr, dmemstore, load_data_out;

   always #5 CLK = ~CLK;

   mem_stage_ctrl #(.DHIT_TIMEOUT(TO), .CNT_W(3)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit),
      .memread_in(memread_in), .memwrite_in(memwrite_in),
      .addr_in(addr_in), .store_in(store_in), .halt_in(halt_in),
      .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .load_data_out(load_data_out), .mem_stall(mem_stall),
      .halt_out(halt_out), .timeout_err(timeout_err)
   );

   // One expected dcache transaction per memory instruction.
   typedef struct {
      logic  ren;
      logic  wen;
      word_t addr;
      word_t st;
      word_t data;
      int    lat;
   } exp_t;

   exp_t  q[$];
   int    checks = 0, errors = 0;
   bit    mon_en = 0, m_halted = 0, exp_halted = 0;
   bit    in_burst = 0, cur_ok = 0;
   exp_t  cur;
   int    stalls = 0;
   word_t cap = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: follows each request burst from first assertion to dhit.
   always @(negedge CLK) begin
      if (mon_en && nRST) begin
         chk("halt_out", halt_out, exp_halted);
         chk("timeout_err_clear", timeout_err, 0);
         if (dmemREN || dmemWEN) begin
            if (!in_burst) begin
               in_burst = 1;
               stalls   = 0;
               cur_ok   = (q.size() != 0);
               if (cur_ok) cur = q.pop_front();
               else begin
                  checks++; errors++;
                  $display("FAIL unexpected_req: REN=%b WEN=%b addr=%h, expected no request at %0t",
                           dmemREN, dmemWEN, dmemaddr, $time);
               end
            end
            if (cur_ok) begin
               chk("ren", dmemREN, cur.ren);
               chk("wen", dmemWEN, cur.wen);
               chk("addr", dmemaddr, cur.addr);
               chk("store", dmemstore, cur.st);
            end
            chk("stall_in_req", mem_stall, !dhit);
            if (dhit) begin
               if (cur_ok) begin
                  chk("stall_cycles", stalls, cur.lat);
                  chk("load_hit", load_data_out, cur.data);
                  cap = cur.data;
               end else cap = dmemload;
               in_burst = 0;
            end else stalls++;
         end else begin
            chk("stall_idle", mem_stall, 0);
            if (in_burst) begin
               checks++; errors++;
               $display("FAIL req_dropped: request went away without dhit at %0t", $time);
               in_burst = 0;
            end
            if (!dhit) chk("load_held", load_data_out, cap);
         end
      end
   end

   // Driver + reference model: one instruction sits in MEM until it advances.
   task automatic issue(input bit rd, input bit wr, input bit hlt, input word_t a,
                        input word_t s, input word_t d, input int lat, input int hold);
      exp_t e;
      memread_in = rd; memwrite_in = wr; halt_in = hlt; addr_in = a; store_in = s;
      if ((rd || wr) && !m_halted) begin
         e.ren = rd && !wr; e.wen = wr; e.addr = a; e.st = s; e.data = d; e.lat = lat;
         q.push_back(e);
         for (int i = 0; i < lat; i++) begin
            dhit = 0; ihit = 1'($urandom); dmemload = $urandom;
            @(posedge CLK); #1;
         end
         dhit = 1; dmemload = d; ihit = (hold == 0);
         @(posedge CLK); #1;
         dhit = 0; dmemload = $urandom;
         if (hold > 0) begin
            ihit = 0;
            repeat (hold) begin @(posedge CLK); #1; end
            ihit = 1;
            @(posedge CLK); #1;
         end
      end else begin
         dhit = 0; dmemload = $urandom; ihit = 1;
         @(posedge CLK); #1;
         if (hlt) begin m_halted = 1; exp_halted = 1; end
      end
      ihit = 0;
   endtask

   initial begin
      // Reset with live-looking inputs: everything must still read 0.
      memread_in = 1; halt_in = 1; ihit = 1; dhit = 1;
      dmemload = 32'hFFFF_FFFF; addr_in = 32'h44; store_in = 32'h55;
      #12;
      chk("rst_ren", dmemREN, 0);
      chk("rst_wen", dmemWEN, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_load", load_data_out, 0);
      chk("rst_addr", dmemaddr, 0);
      chk("rst_halt", halt_out, 0);
      chk("rst_timeout", timeout_err, 0);
      memread_in = 0; halt_in = 0; ihit = 0; dhit = 0; dmemload = '0;
      addr_in = '0; store_in = '0;
      nRST = 1;
      @(posedge CLK); #1;
      mon_en = 1;

      issue(1, 0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 0);
      issue(1, 0, 0, 32'h80, 32'h0, 32'h12345678, 3, 1);
      issue(0, 1, 0, 32'h100, 32'hCAFEF00D, 32'h0BAD0BAD, 0, 2);
      issue(1, 1, 0, 32'h104, 32'h11112222, 32'h33334444, 1, 0);

      for (int n = 0; n < 60; n++) begin
         bit [1:0] k;
         k = 2'($urandom);
         issue(k[0], k[1], 0, $urandom, $urandom, $urandom,
               $urandom_range(0, TO - 1), $urandom_range(0, 2));
      end

      // Watchdog: load that never gets dhit.
      mon_en = 0;
      chk("q_empty_mid", q.size(), 0);
      memread_in = 1; memwrite_in = 0; addr_in = 32'h200; dhit = 0; ihit = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         chk("to_err", timeout_err, (k >= TO));
         chk("to_stall", mem_stall, 1);
         chk("to_ren", dmemREN, 1);
         @(posedge CLK); #1;
      end
      nRST = 0;
      #1;
      chk("abort_ren", dmemREN, 0);
      chk("abort_wen", dmemWEN, 0);
      chk("abort_stall", mem_stall, 0);
      chk("abort_timeout", timeout_err, 0);
      chk("abort_load", load_data_out, 0);
      chk("abort_addr", dmemaddr, 0);
      chk("abort_store", dmemstore, 0);

      memread_in = 0; ihit = 0; dhit = 0;
      #2;
      nRST = 1;
      cap = '0;
      in_burst = 0;
      @(posedge CLK); #1;
      mon_en = 1;

      // Halt, then memory instructions that must never reach the dcache.
      issue(0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0);
      for (int n = 0; n < 4; n++)
         issue(1, n[0], 0, $urandom, $urandom, $urandom, 0, 0);

      @(negedge CLK);
      chk("q_empty_end", q.size(), 0);
      chk("burst_closed", in_burst, 0);
      mon_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
